mario_inputs: RTL and testbench

//  Conditions raw hps_io joystick words into the active-low I_SW1/I_SW2 player ports of mario_top.

---
 rtl/mario_inputs_if.sv | 13 +
 rtl/mario_inputs.sv | 165 ++++++++++++++++
 tb/tb_mario_inputs.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mario_inputs_if.sv
// mario_inputs_if: joystick-in / switch-out bundle between hps_io glue and mario_inputs.
// Ports: I_JOY0/I_JOY1 raw 16-bit joystick words, O_SW1/O_SW2 active-low switch bytes,
//        O_COIN_BUSY coin shaper activity; master = hps side, slave = conditioner.
interface mario_inputs_if;
  logic [15:0] I_JOY0;
  logic [15:0] I_JOY1;
  logic [7:0]  O_SW1;
  logic [7:0]  O_SW2;
  logic        O_COIN_BUSY;

  modport master (output I_JOY0, I_JOY1, input O_SW1, O_SW2, O_COIN_BUSY);
  modport slave  (input I_JOY0, I_JOY1, output O_SW1, O_SW2, O_COIN_BUSY);
endinterface

// File: rtl/mario_inputs.sv
// mario_inputs: sync + debounce joystick bits, 2-way L/R arbitration, start/test/coin merge,
// coin pulse shaper. Latency DEBOUNCE_CYC+3 edges to O_SW (coin +1). No backpressure.
// Ports: I_CLK_24M clock, I_RESETn sync active-low reset, bus (slave) joystick in / switches out.
module mario_inputs #(
  parameter int DEBOUNCE_CYC   = 24000,
  parameter int COIN_PULSE_CYC = 2400000,
  parameter int COIN_GAP_CYC   = 2400000
) (
  input logic           I_CLK_24M,
  input logic           I_RESETn,
  mario_inputs_if.slave bus
);
  // Per player 7 used bits: 0 R, 1 L, 2 jump, 3 start1, 4 start2, 5 coin, 6 test.
  // Player 2 occupies bits 7..13.
  localparam int NB   = 14;
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int CMAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_GAP} coin_st_e;

  logic [NB-1:0] raw, sync1_q, sync2_q, deb;
  logic          unused_joy;

  assign raw = {bus.I_JOY1[8:4], bus.I_JOY1[1:0], bus.I_JOY0[8:4], bus.I_JOY0[1:0]};
  assign unused_joy = ^{bus.I_JOY0[15:9], bus.I_JOY0[3:2], bus.I_JOY1[15:9], bus.I_JOY1[3:2]};

  generate
    if (DEBOUNCE_CYC == 0) begin : g_db_bypass
      assign deb = sync2_q;
    end else begin : g_db
      logic [NB-1:0]   deb_q, deb_d;
      logic [DB_W-1:0] cnt_q [NB];
      logic [DB_W-1:0] cnt_d [NB];

      // Counter runs only while the synchronised bit disagrees with the debounced one;
      // any agreement (a bounce back) restarts it from zero.
      always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
          cnt_d[i] = '0;
          if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) deb_d[i] = sync2_q[i];
            else                                     cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge I_CLK_24M) begin
        if (!I_RESETn) begin
          deb_q <= '0;
          for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
          deb_q <= deb_d;
          for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
      end

      assign deb = deb_q;
    end
  endgenerate

  // L/R arbitration, one lane per player; each lane is {L,R}.
  logic [1:0][1:0] lr, lr_prev_q, last_h_q, last_h_d, lr_out;

  assign lr[0] = deb[1:0];
  assign lr[1] = deb[8:7];

  always_comb begin
    last_h_d = last_h_q;
    lr_out   = lr;
    for (int p = 0; p < 2; p++) begin
      // L is tested first so a same-cycle double edge resolves to L.
      if (lr[p][1] & ~lr_prev_q[p][1])      last_h_d[p] = 2'b10;
      else if (lr[p][0] & ~lr_prev_q[p][0]) last_h_d[p] = 2'b01;
      // Uses the updated history so a fresh edge takes effect in the same cycle.
      if (&lr[p]) lr_out[p] = last_h_d[p];
    end
  end

  // Coin shaper.
  coin_st_e      st_q, st_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          pend_q, pend_d, coin_prev_q, coin, coin_rise;

  assign coin      = deb[5] | deb[12];
  assign coin_rise = coin & ~coin_prev_q;

  always_comb begin
    st_d   = st_q;
    ccnt_d = ccnt_q;
    pend_d = pend_q;
    case (st_q)
      COIN_IDLE: begin
        if (coin_rise) begin
          st_d   = COIN_PULSE;
          ccnt_d = CW'(COIN_PULSE_CYC - 1);
        end
      end
      COIN_PULSE: begin
        if (coin_rise) pend_d = 1'b1;
        if (ccnt_q == '0) begin
          st_d   = COIN_GAP;
          ccnt_d = CW'(COIN_GAP_CYC - 1);
        end else begin
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      COIN_GAP: begin
        if (ccnt_q == '0) begin
          // An edge landing on the final gap cycle still counts as a queued credit.
          if (pend_q | coin_rise) begin
            pend_d = 1'b0;
            st_d   = COIN_PULSE;
            ccnt_d = CW'(COIN_PULSE_CYC - 1);
          end else begin
            st_d = COIN_IDLE;
          end
        end else begin
          if (coin_rise) pend_d = 1'b1;
          ccnt_d = ccnt_q - 1'b1;
        end
      end
      default: st_d = COIN_IDLE;
    endcase
  end

  logic [7:0] sw1_q, sw1_d, sw2_q, sw2_d;

  always_comb begin
    sw1_d = {~(deb[6] | deb[13]), ~(deb[4] | deb[11]), ~(deb[3] | deb[10]), ~deb[2],
             2'b11, ~lr_out[0]};
    sw2_d = {2'b11, ~(st_q == COIN_PULSE), ~deb[9], 2'b11, ~lr_out[1]};
  end

  always_ff @(posedge I_CLK_24M) begin
    if (!I_RESETn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lr_prev_q   <= '0;
      last_h_q    <= '0;
      st_q        <= COIN_IDLE;
      ccnt_q      <= '0;
      pend_q      <= 1'b0;
      coin_prev_q <= 1'b0;
      sw1_q       <= 8'hFF;
      sw2_q       <= 8'hFF;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      lr_prev_q   <= lr;
      last_h_q    <= last_h_d;
      st_q        <= st_d;
      ccnt_q      <= ccnt_d;
      pend_q      <= pend_d;
      coin_prev_q <= coin;
      sw1_q       <= sw1_d;
      sw2_q       <= sw2_d;
    end
  end

  assign bus.O_SW1       = sw1_q;
  assign bus.O_SW2       = sw2_q;
  assign bus.O_COIN_BUSY = (st_q != COIN_IDLE);
endmodule

// File: tb/tb_mario_inputs.sv
// tb_mario_inputs: directed stimulus with a cycle-stamped expectation queue for mario_inputs
// (DEBOUNCE_CYC=4, COIN_PULSE_CYC=10, COIN_GAP_CYC=6). Inputs change 1ns after a rising
// edge; outputs are compared on the falling edge of the cycle stamped in each entry.
module tb_mario_inputs;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mario_inputs_if bus_if ();

  mario_inputs #(
    .DEBOUNCE_CYC  (4),
    .COIN_PULSE_CYC(10),
    .COIN_GAP_CYC  (6)
  ) dut (
    .I_CLK_24M(clk),
    .I_RESETn (rst_n),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  sw1;
    logic [7:0]  sw2;
    logic        busy;
    logic [63:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   n0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      assert (cur.cyc == cyc && bus_if.O_SW1 === cur.sw1 && bus_if.O_SW2 === cur.sw2 &&
              bus_if.O_COIN_BUSY === cur.busy)
      else begin
        errors++;
        $error("FAIL %s cyc=%0d(want %0d) observed sw1=%h sw2=%h busy=%b expected sw1=%h sw2=%h busy=%b",
               cur.tag, cyc, cur.cyc, bus_if.O_SW1, bus_if.O_SW2, bus_if.O_COIN_BUSY,
               cur.sw1, cur.sw2, cur.busy);
      end
    end
  end

  task automatic sb_push(input int c0, input int c1, input logic [7:0] s1, input logic [7:0] s2,
                         input logic b, input logic [63:0] tag);
    for (int c = c0; c <= c1; c++) sb.push_back('{c, s1, s2, b, tag});
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout left=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.I_JOY0 = '0;
    bus_if.I_JOY1 = '0;

    // 1. reset held with random joysticks, then released idle
    @(posedge clk);
    #1;
    n0 = cyc;
    sb_push(n0, n0 + 5, 8'hFF, 8'hFF, 1'b0, "rst_hold");
    sb_push(n0 + 6, n0 + 20, 8'hFF, 8'hFF, 1'b0, "rst_rel ");
    for (int k = 0; k < 5; k++) begin
      bus_if.I_JOY0 = 16'($urandom);
      bus_if.I_JOY1 = 16'($urandom);
      goto(n0 + k + 1);
    end
    rst_n = 1'b1;
    bus_if.I_JOY0 = '0;
    bus_if.I_JOY1 = '0;
    drain();

    // 2. R0 latency, then 3-cycle glitches that must be filtered
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "lat_pre ");
    sb_push(n0 + 7, n0 + 46, 8'hFE, 8'hFF, 1'b0, "lat_glch");
    sb_push(n0 + 47, n0 + 55, 8'hFF, 8'hFF, 1'b0, "lat_rel ");
    bus_if.I_JOY0[0] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      goto(n0 + 15 + 6 * g); bus_if.I_JOY0[0] = 1'b0;
      goto(n0 + 18 + 6 * g); bus_if.I_JOY0[0] = 1'b1;
    end
    goto(n0 + 40); bus_if.I_JOY0[0] = 1'b0;
    drain();

    // 3a. player 1: R then L -> L wins; drop L -> R
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "p1_idle ");
    sb_push(n0 + 7, n0 + 16, 8'hFE, 8'hFF, 1'b0, "p1_r    ");
    sb_push(n0 + 17, n0 + 26, 8'hFD, 8'hFF, 1'b0, "p1_rl   ");
    sb_push(n0 + 27, n0 + 36, 8'hFE, 8'hFF, 1'b0, "p1_r2   ");
    sb_push(n0 + 37, n0 + 45, 8'hFF, 8'hFF, 1'b0, "p1_off  ");
    bus_if.I_JOY0[0] = 1'b1;
    goto(n0 + 10); bus_if.I_JOY0[1] = 1'b1;
    goto(n0 + 20); bus_if.I_JOY0[1] = 1'b0;
    goto(n0 + 30); bus_if.I_JOY0[0] = 1'b0;
    drain();

    // 3b. player 2: L then R -> R wins; both together -> L wins
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "p2_idle ");
    sb_push(n0 + 7, n0 + 16, 8'hFF, 8'hFD, 1'b0, "p2_l    ");
    sb_push(n0 + 17, n0 + 26, 8'hFF, 8'hFE, 1'b0, "p2_lr   ");
    sb_push(n0 + 27, n0 + 36, 8'hFF, 8'hFF, 1'b0, "p2_off  ");
    sb_push(n0 + 37, n0 + 46, 8'hFF, 8'hFD, 1'b0, "p2_same ");
    sb_push(n0 + 47, n0 + 55, 8'hFF, 8'hFF, 1'b0, "p2_off2 ");
    bus_if.I_JOY1[1] = 1'b1;
    goto(n0 + 10); bus_if.I_JOY1[0] = 1'b1;
    goto(n0 + 20); bus_if.I_JOY1[1:0] = 2'b00;
    goto(n0 + 30); bus_if.I_JOY1[1:0] = 2'b11;
    goto(n0 + 40); bus_if.I_JOY1[1:0] = 2'b00;
    drain();

    // merged start/test, jumps, unused bits as noise
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "mrg_pre ");
    sb_push(n0 + 7, n0 + 16, 8'h0F, 8'hED, 1'b0, "mrg_on  ");
    sb_push(n0 + 17, n0 + 25, 8'hFF, 8'hFF, 1'b0, "mrg_off ");
    bus_if.I_JOY0 = 16'hFE5C;
    bus_if.I_JOY1 = 16'hE13A;
    goto(n0 + 10);
    bus_if.I_JOY0 = '0;
    bus_if.I_JOY1 = '0;
    drain();

    // 4. coin held 20 cycles -> single 10-cycle pulse, busy for 16
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "c1_pre  ");
    sb_push(n0 + 7, n0 + 7, 8'hFF, 8'hFF, 1'b1, "c1_start");
    sb_push(n0 + 8, n0 + 17, 8'hFF, 8'hDF, 1'b1, "c1_pulse");
    sb_push(n0 + 18, n0 + 22, 8'hFF, 8'hFF, 1'b1, "c1_gap  ");
    sb_push(n0 + 23, n0 + 45, 8'hFF, 8'hFF, 1'b0, "c1_idle ");
    bus_if.I_JOY1[7] = 1'b1;
    goto(n0 + 20); bus_if.I_JOY1[7] = 1'b0;
    drain();

    // both players' coins in the same cycle -> one credit
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "c2_pre  ");
    sb_push(n0 + 7, n0 + 7, 8'hFF, 8'hFF, 1'b1, "c2_start");
    sb_push(n0 + 8, n0 + 17, 8'hFF, 8'hDF, 1'b1, "c2_pulse");
    sb_push(n0 + 18, n0 + 22, 8'hFF, 8'hFF, 1'b1, "c2_gap  ");
    sb_push(n0 + 23, n0 + 45, 8'hFF, 8'hFF, 1'b0, "c2_idle ");
    bus_if.I_JOY0[7] = 1'b1;
    bus_if.I_JOY1[7] = 1'b1;
    goto(n0 + 6);
    bus_if.I_JOY0[7] = 1'b0;
    bus_if.I_JOY1[7] = 1'b0;
    drain();

    // 5. three presses 8 cycles apart -> two pulses with a 6-cycle gap
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "c3_pre  ");
    sb_push(n0 + 7, n0 + 7, 8'hFF, 8'hFF, 1'b1, "c3_start");
    sb_push(n0 + 8, n0 + 17, 8'hFF, 8'hDF, 1'b1, "c3_p1   ");
    sb_push(n0 + 18, n0 + 23, 8'hFF, 8'hFF, 1'b1, "c3_gap1 ");
    sb_push(n0 + 24, n0 + 33, 8'hFF, 8'hDF, 1'b1, "c3_p2   ");
    sb_push(n0 + 34, n0 + 38, 8'hFF, 8'hFF, 1'b1, "c3_gap2 ");
    sb_push(n0 + 39, n0 + 60, 8'hFF, 8'hFF, 1'b0, "c3_idle ");
    for (int p = 0; p < 3; p++) begin
      goto(n0 + 8 * p);     bus_if.I_JOY0[7] = 1'b1;
      goto(n0 + 8 * p + 4); bus_if.I_JOY0[7] = 1'b0;
    end
    drain();

    // 6. reset during the pulse with a credit pending -> abort, nothing afterwards
    n0 = cyc;
    sb_push(n0, n0 + 6, 8'hFF, 8'hFF, 1'b0, "c4_pre  ");
    sb_push(n0 + 7, n0 + 7, 8'hFF, 8'hFF, 1'b1, "c4_start");
    sb_push(n0 + 8, n0 + 12, 8'hFF, 8'hDF, 1'b1, "c4_pulse");
    sb_push(n0 + 13, n0 + 50, 8'hFF, 8'hFF, 1'b0, "c4_abort");
    bus_if.I_JOY0[7] = 1'b1;
    goto(n0 + 4);  bus_if.I_JOY0[7] = 1'b0;
    goto(n0 + 5);  bus_if.I_JOY1[7] = 1'b1;
    goto(n0 + 11); bus_if.I_JOY1[7] = 1'b0;
    goto(n0 + 12); rst_n = 1'b0;
    goto(n0 + 15); rst_n = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
